// File: rtl/cntrl_pkg.sv
// -----------------------------------------------------------------------------
// cntrl_pkg
//   Shared definitions for the multi-cycle control sequencer:
//     - one-hot state bit indices, state width and the one-hot state enum
//     - instruction class encodings as decoded upstream
//     - helper that derives the wait-timer width from the timeout limit
//   No ports; imported by cntrl_wait_timer and cntrl_sequencer.
// -----------------------------------------------------------------------------
package cntrl_pkg;

  localparam int STATE_W  = 8;

  localparam int IDX_PC   = 0;
  localparam int IDX_IF   = 1;
  localparam int IDX_DEC  = 2;
  localparam int IDX_RF   = 3;
  localparam int IDX_ALU  = 4;
  localparam int IDX_DMEM = 5;
  localparam int IDX_WB   = 6;
  localparam int IDX_ERR  = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_PC   = 8'b0000_0001,
    ST_IF   = 8'b0000_0010,
    ST_DEC  = 8'b0000_0100,
    ST_RF   = 8'b0000_1000,
    ST_ALU  = 8'b0001_0000,
    ST_DMEM = 8'b0010_0000,
    ST_WB   = 8'b0100_0000,
    ST_ERR  = 8'b1000_0000
  } state_t;

  typedef enum logic [1:0] {
    IC_ALU    = 2'd0,
    IC_LOAD   = 2'd1,
    IC_STORE  = 2'd2,
    IC_BRANCH = 2'd3
  } iclass_t;

  // Wait timer must hold values 0..timeout_cyc; never narrower than one bit
  // so a disabled timeout (0) still yields a legal vector.
  function automatic int wait_timer_width(input int timeout_cyc);
    int w;
    w = $clog2(timeout_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cntrl_wait_timer.sv
// -----------------------------------------------------------------------------
// cntrl_wait_timer
//   Counts memory-phase wait cycles and flags when the count has reached the
//   timeout limit. The sequencer clears it whenever it is outside IF/DMEM, so
//   each memory phase starts counting from zero.
//
//   Parameters:
//     TIMEOUT_CYC  wait-cycle limit; 0 disables the timeout (expired stays 0)
//   Ports:
//     clk      in   rising-edge clock
//     I_reset  in   synchronous active-high reset
//     clear    in   force count to zero
//     inc      in   advance count by one (saturating)
//     expired  out  count equals TIMEOUT_CYC
// -----------------------------------------------------------------------------
module cntrl_wait_timer
  import cntrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic I_reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int               TMR_W = wait_timer_width(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMAX  = {TMR_W{1'b1}};

  logic [TMR_W-1:0] count;

  // Clear has priority over increment; saturation keeps a disabled timeout
  // from wrapping during an arbitrarily long wait.
  always_ff @(posedge clk) begin
    if (I_reset || clear) begin
      count <= '0;
    end else if (inc && (count != TMAX)) begin
      count <= count + TMR_W'(1);
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = (count == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/cntrl_sequencer.sv
// -----------------------------------------------------------------------------
// cntrl_sequencer
//   Multi-cycle control sequencer for the 32-bit core. Walks the one-hot phase
//   sequence PC -> IF -> DEC -> RF -> ALU -> {WB | DMEM | PC}, with the path
//   after ALU chosen by the instruction class latched in DEC. Memory phases
//   (IF, DMEM) wait for I_mem_ready and trap into ERR on timeout. A global
//   stall freezes the sequence; ERR is left only through reset.
//
//   Optional build macro: CNTRL_PERF_EN
//     defined   -> retired-instruction and stall/wait-cycle counters are built
//     undefined -> O_retired / O_stall_cyc are tied to zero, no counter flops
//
//   Parameters:
//     CNT_W        performance counter width
//     TIMEOUT_CYC  memory wait limit before trap; 0 disables the trap
//   Ports:
//     clk          in   rising-edge clock
//     I_reset      in   synchronous active-high reset
//     I_iclass     in   instruction class (0 ALU, 1 LOAD, 2 STORE, 3 BRANCH)
//     I_mem_ready  in   memory handshake for IF / DMEM
//     I_stall      in   global freeze
//     O_enpc .. O_enwb  out  per-unit enables (state gated by ~I_stall)
//     O_memwe      out  data-memory write strobe (STORE in DMEM)
//     O_state      out  current one-hot state
//     O_busy       out  high outside PC and ERR
//     O_err        out  sticky timeout trap flag
//     O_retired    out  retired instruction count (saturating)
//     O_stall_cyc  out  stalled / waiting cycle count (saturating)
// -----------------------------------------------------------------------------
module cntrl_sequencer
  import cntrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               I_reset,
  input  logic [1:0]         I_iclass,
  input  logic               I_mem_ready,
  input  logic               I_stall,
  output logic               O_enpc,
  output logic               O_enmem,
  output logic               O_endec,
  output logic               O_enrg,
  output logic               O_enalu,
  output logic               O_enwb,
  output logic               O_memwe,
  output logic [STATE_W-1:0] O_state,
  output logic               O_busy,
  output logic               O_err,
  output logic [CNT_W-1:0]   O_retired,
  output logic [CNT_W-1:0]   O_stall_cyc
);

  state_t  state_q;
  iclass_t class_q;
  logic    err_q;
  logic    in_wait;
  logic    tmr_inc;
  logic    expired;

  assign in_wait = (state_q == ST_IF) || (state_q == ST_DMEM);
  assign tmr_inc = in_wait && !I_mem_ready && !I_stall;

  // Held clear outside the memory phases, so entry to IF/DMEM sees zero.
  cntrl_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (clk),
    .I_reset (I_reset),
    .clear   (!in_wait),
    .inc     (tmr_inc),
    .expired (expired)
  );

  // Phase sequencing. Stall freezes everything except ERR (which is frozen
  // anyway). In memory phases ready is checked before expiry so a late ready
  // still completes the phase. The class is latched only on the cycle DEC
  // actually advances; anything not one-hot falls back to PC.
  always_ff @(posedge clk) begin
    if (I_reset) begin
      state_q <= ST_PC;
      class_q <= IC_ALU;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_PC: begin
          if (!I_stall) state_q <= ST_IF;
        end
        ST_IF: begin
          if (!I_stall) begin
            if (I_mem_ready) begin
              state_q <= ST_DEC;
            end else if (expired) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        ST_DEC: begin
          if (!I_stall) begin
            class_q <= iclass_t'(I_iclass);
            state_q <= ST_RF;
          end
        end
        ST_RF: begin
          if (!I_stall) state_q <= ST_ALU;
        end
        ST_ALU: begin
          if (!I_stall) begin
            case (class_q)
              IC_ALU:            state_q <= ST_WB;
              IC_LOAD, IC_STORE: state_q <= ST_DMEM;
              default:           state_q <= ST_PC;
            endcase
          end
        end
        ST_DMEM: begin
          if (!I_stall) begin
            if (I_mem_ready) begin
              state_q <= (class_q == IC_STORE) ? ST_PC : ST_WB;
            end else if (expired) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        ST_WB: begin
          if (!I_stall) state_q <= ST_PC;
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          state_q <= ST_PC;
        end
      endcase
    end
  end

  assign O_state = state_q;
  assign O_err   = err_q;
  assign O_busy  = !(state_q[IDX_PC] || state_q[IDX_ERR]);

  assign O_enpc  = state_q[IDX_PC]  & ~I_stall;
  assign O_enmem = (state_q[IDX_IF] | state_q[IDX_DMEM]) & ~I_stall;
  assign O_endec = state_q[IDX_DEC] & ~I_stall;
  assign O_enrg  = state_q[IDX_RF]  & ~I_stall;
  assign O_enalu = state_q[IDX_ALU] & ~I_stall;
  assign O_enwb  = state_q[IDX_WB]  & ~I_stall;

  // The write strobe is frozen with the rest of the datapath so a stalled
  // DMEM cycle cannot issue a duplicate store.
  assign O_memwe = state_q[IDX_DMEM] & (class_q == IC_STORE) & ~I_stall;

`ifdef CNTRL_PERF_EN
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             retire_evt;
  logic             stall_evt;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] stall_cyc_q;

  // A retire is any non-stalled edge that lands in PC from a final phase.
  assign retire_evt = !I_stall &&
                      ((state_q == ST_WB) ||
                       ((state_q == ST_DMEM) && I_mem_ready && (class_q == IC_STORE)) ||
                       ((state_q == ST_ALU) && (class_q == IC_BRANCH)));

  assign stall_evt  = I_stall || (in_wait && !I_mem_ready);

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (I_reset) begin
      retired_q   <= '0;
      stall_cyc_q <= '0;
    end else begin
      if (retire_evt && (retired_q != CMAX)) retired_q <= retired_q + CNT_W'(1);
      if (stall_evt && (stall_cyc_q != CMAX)) stall_cyc_q <= stall_cyc_q + CNT_W'(1);
    end
  end

  assign O_retired   = retired_q;
  assign O_stall_cyc = stall_cyc_q;
`else
  assign O_retired   = '0;
  assign O_stall_cyc = '0;
`endif

endmodule

// File: doc/cntrl_sequencer.md
# cntrl_sequencer

Parametrised multi-cycle control sequencer for the 32-bit core. It drives the per-phase unit enables (PC, memory, decode, register file, ALU, write-back) and selects a per-class phase path, so ALU, load, store and branch instructions take different cycle counts. It waits on a memory-ready handshake, supports a global stall, and traps on memory timeout. It sits between the decoder (instruction class, stall) and the datapath units.

## Interface
- `CNT_W`, 32: width of the performance counters.
- `TIMEOUT_CYC`, 16: maximum wait cycles in a memory phase before trap; 0 disables the timeout.
- `clk` in 1: the only clock; all logic is on its rising edge.
- `I_reset` in 1: reset, synchronous and active-high.
- `I_iclass` in 2: instruction class, sampled in DEC. 0 = ALU, 1 = LOAD, 2 = STORE, 3 = BRANCH.
- `I_mem_ready` in 1: memory handshake; a phase completes on a cycle with ready = 1.
- `I_stall` in 1: global freeze.
- `O_enpc`, `O_enmem`, `O_endec`, `O_enrg`, `O_enalu`, `O_enwb` out 1 each: unit enables.
- `O_memwe` out 1: data-memory write strobe; high in DMEM for STORE only.
- `O_state` out 8: current one-hot state.
- `O_busy` out 1: high in every state except PC and ERR.
- `O_err` out 1: timeout trap flag; sticky.
- `O_retired` out CNT_W: count of retired instructions.
- `O_stall_cyc` out CNT_W: count of stalled or waiting cycles.

## Operation
- One-hot states, with bit index:
  - PC[0], IF[1], DEC[2], RF[3], ALU[4], DMEM[5], WB[6], ERR[7].
- Transitions:
  - PC→IF and DEC→RF→ALU are unconditional.
  - IF→DEC on `I_mem_ready`.
  - In DEC, the class is latched into a 2-bit register.
  - From ALU: ALU class goes to WB; LOAD and STORE go to DMEM; BRANCH goes to PC.
  - DMEM→WB (LOAD) or DMEM→PC (STORE) on `I_mem_ready`.
  - WB→PC.
- ERR is entered when the wait timer reaches `TIMEOUT_CYC` in IF or DMEM with ready still low. ERR is left only by reset.
- Enables are `state & ~I_stall`:
  - `O_enpc` = PC.
  - `O_enmem` = IF | DMEM.
  - `O_endec` = DEC.
  - `O_enrg` = RF.
  - `O_enalu` = ALU.
  - `O_enwb` = WB.
- Any illegal state (not one-hot) goes to PC on the next edge.
- Stall:
  - State and wait timer hold while `I_stall` = 1.
  - Stall has priority over ready and over timeout.
  - Stall is ignored in ERR.
- Wait timer:
  - Clears on entry to IF or DMEM.
  - Increments each cycle in IF or DMEM with ready = 0 and no stall.
  - Trap when the count equals `TIMEOUT_CYC`.
- Retire: an edge that moves into PC from WB, DMEM (STORE) or ALU (BRANCH).

## Timing
- Reset values:
  - state = PC, so `O_enpc` = 1 in the first cycle after reset unless stalled.
  - All other enables = 0; `O_err` = 0; counters = 0; class register = ALU.
- Cycles per instruction with zero-wait memory and no stall:
  - ALU 6, LOAD 7, STORE 6, BRANCH 5.
  - Each wait or stall cycle adds 1.
- `I_mem_ready` is sampled only in IF or DMEM; it is ignored elsewhere.
- A ready in the same cycle the timer hits `TIMEOUT_CYC` wins: the phase advances and there is no trap.
- `O_err` rises on the edge that enters ERR.
- Reset during any phase, including ERR, returns to PC on the next edge. In-flight work is abandoned and not counted.
- Counters saturate at all-ones and never wrap.

## Configuration
- `CNTRL_PERF_EN` defined:
  - `O_retired` increments on each retire.
  - `O_stall_cyc` increments on every cycle with `I_stall` = 1, or in IF/DMEM with ready = 0.
- `CNTRL_PERF_EN` undefined:
  - Both ports remain and are tied to 0; no counter flops are built.
  - Sequencing is identical with and without the macro.

## Structure
- Package `cntrl_pkg` holds:
  - one-hot state localparams and the state width (8);
  - iclass encodings;
  - the derived wait-timer width, `$clog2(TIMEOUT_CYC+1)` with a minimum of 1.
- Sub-module `cntrl_wait_timer` holds the clear/increment/hold counter and the timeout compare. It outputs `expired`.

## Test plan
- Reset, then ALU class, ready always 1 → `O_state` goes 01,02,04,08,10,40,01 over 6 cycles; `O_retired` = 1.
- LOAD class, ready held low 3 cycles in DMEM, `TIMEOUT_CYC`=16 → 10 cycles total; `O_stall_cyc` = 3; `O_enwb` pulses once.
- STORE → `O_memwe` = 1 only in DMEM; returns DMEM→PC with no WB; 6 cycles.
- Ready low 16 cycles in IF → ERR (`O_state` = 80, `O_err` = 1). Stays there with ready = 1; `I_reset` → `O_state` = 01, `O_err` = 0.
- `I_stall` = 1 for 4 cycles in ALU → state held and all enables 0; retire delayed by 4; `O_stall_cyc` = 4.
- BRANCH with `I_reset` asserted in RF → next state PC; `O_retired` unchanged. Build without `CNTRL_PERF_EN` → counters read 0.
